uart_cmd_seq: RTL and testbench
===============================

Name: uart_cmd_seq

Overview:
- Command sequencer on the receive side of the UART receiver.
- Consumes received bytes through the receiver's rdy/clr_rdy handshake and assembles NBYTES bytes into one command word.
- Presents each command to the downstream command processor with a valid/ack handshake.
- Discards partial commands after an inter-byte timeout.
- Owns the receiver's 13-bit baud divisor (DB), which can be reconfigured only while the link is idle.

Parameters:
NBYTES, 3, bytes per command; legal range 1-8
TMO_CYC, 1000000, clock cycles allowed between bytes of one command before the partial command is discarded; must be >= 2
DB_DEFAULT, 13'd434, baud divisor loaded at reset (50 MHz / 115200)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
rx_rdy  input  1  byte available from UART receiver
rx_data  input  8  received byte
clr_rdy  output  1  consume strobe to receiver; combinational, one cycle
DB  output  13  baud divisor to receiver
set_db  input  1  request to load db_in into DB
db_in  input  13  new divisor value
cmd  output  8*NBYTES  assembled command; first byte received in the MS byte
cmd_vld  output  1  cmd holds a complete command
cmd_ack  input  1  downstream accepted cmd
tmo_err  output  1  one-cycle pulse: partial command discarded
cfg_err  output  1  one-cycle pulse: set_db rejected

Behaviour:
- Reset values:
  - state=IDLE; cmd=0; cmd_vld=0; tmo_err=0; cfg_err=0.
  - DB=DB_DEFAULT; byte count=0; timeout counter=0.
  - clr_rdy=0 (combinational output, 0 throughout reset).
- States are IDLE, ACCUM, HOLD. clr_rdy=1 exactly in the cycles where a byte is captured.
- IDLE with rx_rdy=1:
  - Capture: cmd <= {cmd[8*NBYTES-9:0], rx_data}; count=1; clr_rdy=1.
  - Go to ACCUM, or go directly to HOLD with cmd_vld<=1 when NBYTES=1.
- ACCUM with rx_rdy=1:
  - Capture byte and shift it into cmd; count+1; timeout counter cleared; clr_rdy=1.
  - When the capture makes count==NBYTES: count<=0, cmd_vld<=1, go to HOLD.
- ACCUM with rx_rdy=0:
  - Timeout counter increments each cycle.
  - When it reaches TMO_CYC-1: tmo_err pulses next cycle, count<=0, counter<=0, go to IDLE.
  - cmd is not cleared, and a stale cmd is never flagged valid.
- Simultaneous rx_rdy and timeout terminal count: the byte wins. It is captured, the counter is cleared, and no tmo_err is raised.
- HOLD:
  - cmd and cmd_vld are held stable and clr_rdy=0.
  - A pending rx_rdy is left unconsumed; the receiver holds it until IDLE.
  - cmd_ack=1 gives cmd_vld<=0 and a transition to IDLE.
  - A byte pending at that point is captured in the first IDLE cycle.
- cmd_ack while cmd_vld=0 is ignored.
- Latency: a final byte seen in cycle T gives cmd_vld=1 in T+1. The earliest next-byte capture is 1 cycle after ack.
- DB:
  - set_db=1 in IDLE with rx_rdy=0 gives DB<=db_in on the next edge.
  - set_db in any other condition (ACCUM, HOLD, or IDLE with rx_rdy=1) is ignored: DB unchanged, and cfg_err pulses the next cycle.
  - db_in values below 13'd16 are rejected the same way.
- Timeout counter is 20 bits minimum, sized $clog2(TMO_CYC). It saturates only via the terminal-count rule and never wraps silently.
- Reset mid-command or during HOLD: the partial or held command is lost, and outputs return to their reset values immediately (asynchronous).

Decomposition:
- Package uart_cmd_pkg:
  - state_t enum {IDLE, ACCUM, HOLD}.
  - DB_MIN=13'd16 and DB_DEFAULT_115K=13'd434 constants.
- Sub-module byte_tmo_timer:
  - Inputs: clr, en.
  - Output: expired (terminal-count pulse).
  - Parameterised by TMO_CYC.
- Byte assembly, the handshake FSM and the DB register stay in uart_cmd_seq.

Test Plan:
- NBYTES=3; bytes 0xA5, 0x01, 0x7F spaced 20 cycles -> cmd=24'hA5017F, cmd_vld high 1 cycle after third clr_rdy. Exactly 3 clr_rdy pulses.
- Hold cmd_ack=0 for 50 cycles; byte 0x33 arrives -> clr_rdy stays 0 and cmd stable. Ack -> 0x33 captured on the cycle after the IDLE transition.
- TMO_CYC=100; send 0x11 then silence -> tmo_err pulse 100 cycles after capture, state IDLE. Next 3 bytes 0x22, 0x33, 0x44 -> cmd=24'h223344.
- Byte arrives on the exact timeout terminal cycle -> no tmo_err; byte counted.
- set_db with db_in=13'd868 in IDLE -> DB=868. The same request mid-ACCUM -> cfg_err pulse, DB unchanged. db_in=13'd5 -> rejected.
- Assert rst_n low during ACCUM after 2 bytes -> cmd_vld=0, DB=434. The next 3 bytes form a fresh command.

Source files
------------

// File: rtl/uart_cmd_seq_pkg.sv
// uart_cmd_seq shared types and constants.
// Receive-side command sequencer package.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam logic [12:0] DB_MIN          = 13'd16;
  localparam logic [12:0] DB_DEFAULT_115K = 13'd434;

endpackage

// File: rtl/uart_cmd_seq_if.sv
// Receiver byte handshake and command handshake bundle.
// slave = sequencer side, master = environment side.
interface uart_cmd_seq_if #(
  parameter int NBYTES = 3
);

  logic                  rx_rdy;
  logic [7:0]            rx_data;
  logic                  clr_rdy;
  logic [8*NBYTES-1:0]   cmd;
  logic                  cmd_vld;
  logic                  cmd_ack;

  modport master (
    output rx_rdy, rx_data, cmd_ack,
    input  clr_rdy, cmd, cmd_vld
  );

  modport slave (
    input  rx_rdy, rx_data, cmd_ack,
    output clr_rdy, cmd, cmd_vld
  );

endinterface

// File: rtl/uart_cmd_seq_byte_tmo_timer.sv
// Inter-byte timeout counter.
// expired is a combinational terminal-count pulse.
module byte_tmo_timer #(
  parameter int TMO_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CLW = $clog2(TMO_CYC);
  localparam int W   = (CLW > 20) ? CLW : 20;
  localparam logic [W-1:0] TERM = W'(TMO_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == TERM);

  // count idle cycles; terminal count and clr both restart from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_seq.sv
// UART receive-side command sequencer.
// Assembles NBYTES bytes into a command, owns baud divisor.
module uart_cmd_seq
  import uart_cmd_pkg::*;
#(
  parameter int          NBYTES     = 3,
  parameter int          TMO_CYC    = 1000000,
  parameter logic [12:0] DB_DEFAULT = DB_DEFAULT_115K
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_cmd_seq_if.slave bus,
  output logic [12:0]   DB,
  input  logic          set_db,
  input  logic [12:0]   db_in,
  output logic          tmo_err,
  output logic          cfg_err
);

  localparam int CW   = 8 * NBYTES;
  localparam int CNTW = $clog2(NBYTES + 1);
  localparam logic [CNTW-1:0] NB = CNTW'(NBYTES);

  state_t          state_q, state_d;
  logic [CW-1:0]   cmd_q, cmd_d;
  logic            vld_q, vld_d;
  logic [CNTW-1:0] bcnt_q, bcnt_d;
  logic [12:0]     db_q, db_d;
  logic            tmo_q, tmo_d;
  logic            cfg_q, cfg_d;
  logic            cap;
  logic            expired;
  logic            db_ok;
  logic [CW-1:0]   shifted;

  byte_tmo_timer #(
    .TMO_CYC(TMO_CYC)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cap),
    .en     ((state_q == ACCUM) && !bus.rx_rdy),
    .expired(expired)
  );

  assign shifted = (cmd_q << 8) | CW'(bus.rx_data);
  assign db_ok   = (state_q == IDLE) && !bus.rx_rdy
                && (db_in >= DB_MIN);

  // handshake FSM, byte assembly and divisor update
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    vld_d   = vld_q;
    bcnt_d  = bcnt_q;
    db_d    = db_q;
    tmo_d   = 1'b0;
    cfg_d   = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.rx_rdy) begin
          cap   = 1'b1;
          cmd_d = shifted;
          if (NBYTES == 1) begin
            bcnt_d  = '0;
            vld_d   = 1'b1;
            state_d = HOLD;
          end else begin
            bcnt_d  = CNTW'(1);
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (bus.rx_rdy) begin
          cap   = 1'b1;
          cmd_d = shifted;
          if (bcnt_q == NB - 1'b1) begin
            bcnt_d  = '0;
            vld_d   = 1'b1;
            state_d = HOLD;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else if (expired) begin
          tmo_d   = 1'b1;
          bcnt_d  = '0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.cmd_ack) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    unique case (1'b1)
      (set_db && db_ok):  db_d  = db_in;
      (set_db && !db_ok): cfg_d = 1'b1;
      default: ;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      vld_q   <= 1'b0;
      bcnt_q  <= '0;
      db_q    <= DB_DEFAULT;
      tmo_q   <= 1'b0;
      cfg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
      bcnt_q  <= bcnt_d;
      db_q    <= db_d;
      tmo_q   <= tmo_d;
      cfg_q   <= cfg_d;
    end
  end

  assign bus.clr_rdy = cap & rst_n;
  assign bus.cmd     = cmd_q;
  assign bus.cmd_vld = vld_q;
  assign DB          = db_q;
  assign tmo_err     = tmo_q;
  assign cfg_err     = cfg_q;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Self-checking bench for uart_cmd_seq.
// Reference: byte queue model with cycle-gap timeout rule.
module tb_uart_cmd_seq;
  import uart_cmd_pkg::*;

  localparam int NB  = 3;
  localparam int TMO = 100;
  localparam int CW  = 8 * NB;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        set_db = 1'b0;
  logic [12:0] db_in  = '0;
  logic [12:0] DB;
  logic        tmo_err;
  logic        cfg_err;

  uart_cmd_seq_if #(.NBYTES(NB)) bus ();

  uart_cmd_seq #(
    .NBYTES    (NB),
    .TMO_CYC   (TMO),
    .DB_DEFAULT(13'd434)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .DB     (DB),
    .set_db (set_db),
    .db_in  (db_in),
    .tmo_err(tmo_err),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int nclr  = 0;
  int ntmo  = 0;
  int ncfg  = 0;
  int exp_clr = 0;
  int exp_tmo = 0;
  int exp_cfg = 0;
  logic [7:0] part[$];
  logic [CW-1:0] held;

  // pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    #2;
    if (bus.clr_rdy) nclr++;
    if (tmo_err) ntmo++;
    if (cfg_err) ncfg++;
  end

  function automatic logic [CW-1:0] packq();
    logic [CW-1:0] a;
    a = '0;
    foreach (part[i]) a = (a << 8) | CW'(part[i]);
    return a;
  endfunction

  task automatic put_byte(input logic [7:0] b,
                          output bit ok);
    ok = 0;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (bus.clr_rdy) ok = 1;
      @(negedge clk);
    end
    bus.rx_rdy = 1'b0;
  endtask

  // gap = idle cycles since the previous capture
  task automatic send(input logic [7:0] b,
                      input int gap,
                      output bit done);
    bit ok;
    logic [CW-1:0] e;
    done = 0;
    repeat (gap) @(negedge clk);
    if (gap >= TMO && part.size() > 0) begin
      part.delete();
      exp_tmo++;
    end
    put_byte(b, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL capture: byte %h not consumed", b);
    end
    exp_clr++;
    part.push_back(b);
    if (part.size() == NB) begin
      e = packq();
      #1;
      tests++;
      if (bus.cmd_vld !== 1'b1 || bus.cmd !== e) begin
        fails++;
        $display("FAIL cmd: vld=%b cmd=%h want vld=1 cmd=%h",
                 bus.cmd_vld, bus.cmd, e);
      end
      held = e;
      part.delete();
      done = 1;
      @(negedge clk);
    end
  endtask

  task automatic ack_cmd(input int d);
    bit bad;
    bad = 0;
    repeat (d) begin
      #1;
      if (bus.cmd_vld !== 1'b1 || bus.cmd !== held) bad = 1;
      @(negedge clk);
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL hold_stable: cmd=%h want %h",
               bus.cmd, held);
    end
    bus.cmd_ack = 1'b1;
    @(negedge clk);
    bus.cmd_ack = 1'b0;
    #1;
    tests++;
    if (bus.cmd_vld !== 1'b0) begin
      fails++;
      $display("FAIL ack: vld=%b want 0", bus.cmd_vld);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'hFF;
    bus.cmd_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (bus.clr_rdy !== 1'b0 || bus.cmd_vld !== 1'b0 ||
        bus.cmd !== '0 || tmo_err !== 1'b0 ||
        cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: clr=%b vld=%b cmd=%h tmo=%b cfg=%b want 0",
               bus.clr_rdy, bus.cmd_vld, bus.cmd,
               tmo_err, cfg_err);
    end
    tests++;
    if (DB !== 13'd434) begin
      fails++;
      $display("FAIL reset_db: DB=%0d want 434", DB);
    end
    @(negedge clk);
    bus.rx_rdy = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit d;
    int c0;
    c0 = nclr;
    send(8'hA5, 0, d);
    send(8'h01, 20, d);
    #1;
    tests++;
    if (bus.cmd_vld !== 1'b0) begin
      fails++;
      $display("FAIL early_vld: vld=%b want 0", bus.cmd_vld);
    end
    send(8'h7F, 19, d);
    tests++;
    if (held !== 24'hA5017F || !d) begin
      fails++;
      $display("FAIL basic_cmd: cmd=%h want a5017f", held);
    end
    tests++;
    if (nclr - c0 != 3) begin
      fails++;
      $display("FAIL basic_clr: pulses=%0d want 3", nclr - c0);
    end
    ack_cmd(4);
  endtask

  task automatic test_hold();
    bit d;
    bit bad;
    bad = 0;
    send(8'hC1, 0, d);
    send(8'hC2, 0, d);
    send(8'hC3, 0, d);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h33;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.clr_rdy !== 1'b0 || bus.cmd !== held ||
          bus.cmd_vld !== 1'b1) bad = 1;
      @(negedge clk);
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL hold_block: clr=%b cmd=%h want clr=0 cmd=%h",
               bus.clr_rdy, bus.cmd, held);
    end
    bus.cmd_ack = 1'b1;
    #1;
    tests++;
    if (bus.clr_rdy !== 1'b0) begin
      fails++;
      $display("FAIL hold_ack_clr: clr=%b want 0", bus.clr_rdy);
    end
    @(negedge clk);
    bus.cmd_ack = 1'b0;
    #1;
    tests++;
    if (bus.clr_rdy !== 1'b1 || bus.cmd_vld !== 1'b0) begin
      fails++;
      $display("FAIL post_ack: clr=%b vld=%b want 1 0",
               bus.clr_rdy, bus.cmd_vld);
    end
    @(negedge clk);
    bus.rx_rdy = 1'b0;
    exp_clr++;
    part.push_back(8'h33);
    send(8'h34, 0, d);
    send(8'h35, 0, d);
    tests++;
    if (held !== 24'h333435) begin
      fails++;
      $display("FAIL hold_next: cmd=%h want 333435", held);
    end
    ack_cmd(2);
  endtask

  task automatic test_timeout();
    bit d;
    send(8'h11, 0, d);
    repeat (TMO - 1) @(negedge clk);
    #1;
    tests++;
    if (tmo_err !== 1'b0) begin
      fails++;
      $display("FAIL tmo_early: tmo=%b want 0", tmo_err);
    end
    @(negedge clk);
    #1;
    tests++;
    if (tmo_err !== 1'b1 || bus.cmd_vld !== 1'b0) begin
      fails++;
      $display("FAIL tmo_pulse: tmo=%b vld=%b want 1 0",
               tmo_err, bus.cmd_vld);
    end
    exp_tmo++;
    part.delete();
    @(negedge clk);
    #1;
    tests++;
    if (tmo_err !== 1'b0) begin
      fails++;
      $display("FAIL tmo_width: tmo=%b want 0", tmo_err);
    end
    @(negedge clk);
    send(8'h22, 0, d);
    send(8'h33, 0, d);
    send(8'h44, 0, d);
    tests++;
    if (held !== 24'h223344) begin
      fails++;
      $display("FAIL tmo_next: cmd=%h want 223344", held);
    end
    ack_cmd(1);
  endtask

  task automatic test_terminal();
    bit d;
    int t0;
    t0 = ntmo;
    send(8'h55, 0, d);
    send(8'h66, TMO - 1, d);
    send(8'h77, TMO - 1, d);
    tests++;
    if (ntmo != t0 || held !== 24'h556677) begin
      fails++;
      $display("FAIL terminal: tmo=%0d cmd=%h want 0 556677",
               ntmo - t0, held);
    end
    ack_cmd(0);
  endtask

  task automatic test_db();
    bit d;
    set_db = 1'b1;
    db_in  = 13'd868;
    @(negedge clk);
    set_db = 1'b0;
    #1;
    tests++;
    if (DB !== 13'd868 || cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL db_load: DB=%0d cfg=%b want 868 0",
               DB, cfg_err);
    end
    @(negedge clk);
    send(8'h01, 0, d);
    set_db = 1'b1;
    db_in  = 13'd1000;
    @(negedge clk);
    set_db = 1'b0;
    exp_cfg++;
    #1;
    tests++;
    if (cfg_err !== 1'b1 || DB !== 13'd868) begin
      fails++;
      $display("FAIL db_accum: cfg=%b DB=%0d want 1 868",
               cfg_err, DB);
    end
    @(negedge clk);
    send(8'h02, 0, d);
    send(8'h03, 0, d);
    ack_cmd(0);
    set_db = 1'b1;
    db_in  = 13'd5;
    @(negedge clk);
    set_db = 1'b0;
    exp_cfg++;
    #1;
    tests++;
    if (cfg_err !== 1'b1 || DB !== 13'd868) begin
      fails++;
      $display("FAIL db_small: cfg=%b DB=%0d want 1 868",
               cfg_err, DB);
    end
    @(negedge clk);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'hAB;
    set_db      = 1'b1;
    db_in       = 13'd900;
    @(negedge clk);
    bus.rx_rdy = 1'b0;
    set_db     = 1'b0;
    exp_cfg++;
    exp_clr++;
    #1;
    tests++;
    if (cfg_err !== 1'b1 || DB !== 13'd868) begin
      fails++;
      $display("FAIL db_rxrdy: cfg=%b DB=%0d want 1 868",
               cfg_err, DB);
    end
    repeat (TMO) @(negedge clk);
    exp_tmo++;
    @(negedge clk);
    tests++;
    if (ncfg != exp_cfg) begin
      fails++;
      $display("FAIL db_cfgcnt: cfg=%0d want %0d", ncfg, exp_cfg);
    end
  endtask

  task automatic test_rst_mid();
    bit d;
    send(8'h9A, 0, d);
    send(8'h9B, 3, d);
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.cmd_vld !== 1'b0 || DB !== 13'd434 ||
        bus.cmd !== '0) begin
      fails++;
      $display("FAIL rst_mid: vld=%b DB=%0d cmd=%h want 0 434 0",
               bus.cmd_vld, DB, bus.cmd);
    end
    part.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'hD0, 0, d);
    send(8'hD1, 1, d);
    send(8'hD2, 2, d);
    tests++;
    if (held !== 24'hD0D1D2) begin
      fails++;
      $display("FAIL rst_fresh: cmd=%h want d0d1d2", held);
    end
    ack_cmd(1);
  endtask

  task automatic test_random();
    bit d;
    int g;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: g = 0;
        1: g = $urandom_range(1, 3);
        2: g = TMO - 1;
        3: g = TMO;
        4: g = TMO + $urandom_range(1, 5);
        default: g = $urandom_range(4, 30);
      endcase
      send(8'($urandom), g, d);
      if (d) ack_cmd($urandom_range(0, 6));
    end
    if (part.size() > 0) begin
      exp_tmo++;
      part.delete();
    end
    repeat (TMO + 3) @(negedge clk);
    tests++;
    if (nclr != exp_clr) begin
      fails++;
      $display("FAIL clr_total: %0d want %0d", nclr, exp_clr);
    end
    tests++;
    if (ntmo != exp_tmo) begin
      fails++;
      $display("FAIL tmo_total: %0d want %0d", ntmo, exp_tmo);
    end
  endtask

  initial begin
    bus.rx_rdy  = 1'b0;
    bus.rx_data = '0;
    bus.cmd_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_hold();
    test_timeout();
    test_terminal();
    test_db();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
